// File: rtl/vote_sequencer.sv
// Iterative vote sequencer: strobes a datapath through load/update cycles until at least
// K_MIN channel zero-flags are set, or gives up after MAX_ITER evaluations.
module vote_sequencer #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned K_MIN    = 3,
  parameter int unsigned MAX_ITER = 15,
  localparam int unsigned SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned IT_W    = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1,
  localparam int unsigned CNT_W   = $clog2(N_CH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_CH-1:0]  z,
  output logic             init,
  output logic             upd,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [IT_W-1:0]  iter_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StStepA,
    StStepB,
    StEval,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IT_W-1:0]   iter_q, iter_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  pop;
  logic [SEL_W-1:0]  first_zero;
  logic              hit, last;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pop = pop + CNT_W'(z[i]);
    end
  end

  // Scan from the top so the lowest cleared index wins.
  always_comb begin
    first_zero = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (!z[i]) first_zero = SEL_W'(i);
    end
  end

  assign hit  = (pop >= CNT_W'(K_MIN));
  assign last = (iter_q == IT_W'(MAX_ITER - 1));

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle:  if (start) state_d = StInit;
      StInit:  state_d = StStepA;
      StStepA: state_d = StStepB;
      StStepB: state_d = StEval;
      StEval: begin
        if (hit || last) begin
          state_d   = StDone;
          timeout_d = !hit;
        end else begin
          state_d = StStepA;
          iter_d  = iter_q + IT_W'(1);
        end
      end
      StDone:  if (start) state_d = StInit;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      iter_d  = '0;
    end
    // INIT is only reachable from IDLE or DONE, so this is always an entry.
    if (state_d == StInit) iter_d = '0;
    if (state_d == StInit || state_d == StIdle) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
    end
  end

  assign init     = (state_q == StInit);
  assign upd      = (state_q == StEval);
  assign busy     = (state_q == StInit) || (state_q == StStepA) ||
                    (state_q == StStepB) || (state_q == StEval);
  assign done     = (state_q == StDone);
  assign sel      = (state_q == StEval) ? first_zero : '0;
  assign timeout  = timeout_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_vote_sequencer.sv
// Bench for vote_sequencer: directed scenarios plus random runs checked against a
// run-level model that predicts every cycle from the start edge with plain arithmetic.
module tb_vote_sequencer;

  localparam int N_CH     = 4;
  localparam int K_MIN    = 3;
  localparam int MAX_ITER = 4;
  localparam int SEL_W    = 2;
  localparam int IT_W     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [N_CH-1:0]  z;
  logic             init;
  logic             upd;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [IT_W-1:0]  iter_cnt;

  int vectors     = 0;
  int miscompares = 0;

  vote_sequencer #(
    .N_CH    (N_CH),
    .K_MIN   (K_MIN),
    .MAX_ITER(MAX_ITER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .z       (z),
    .init    (init),
    .upd     (upd),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_init, input int e_upd,
                            input int e_busy, input int e_done, input int e_to,
                            input int e_sel, input int e_it);
    chk({tag, ".init"},     32'(init),     32'(e_init));
    chk({tag, ".upd"},      32'(upd),      32'(e_upd));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
    chk({tag, ".done"},     32'(done),     32'(e_done));
    chk({tag, ".timeout"},  32'(timeout),  32'(e_to));
    chk({tag, ".sel"},      32'(sel),      32'(e_sel));
    chk({tag, ".iter_cnt"}, 32'(iter_cnt), 32'(e_it));
  endtask

  function automatic int lowest_zero(input logic [N_CH-1:0] v);
    int r;
    bit found;
    r     = 0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && !v[i]) begin
        r     = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // zs[e] is the flag vector presented during evaluation e. After the start edge (t=0)
  // INIT occupies t=0 and each evaluation e spans t=3e+1..3e+3 with EVAL at t=3e+3.
  task automatic do_run(input string tag, input logic [N_CH-1:0] zs [MAX_ITER],
                        input int abort_at, input int hold);
    int e_fin, t_end, e, p;
    string tt;
    e_fin = MAX_ITER - 1;
    for (int k = MAX_ITER - 1; k >= 0; k--) begin
      if ($countones(zs[k]) >= K_MIN) e_fin = k;
    end
    t_end = 3 * e_fin + 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= t_end + hold; t++) begin
      e = (t - 1) / 3;
      p = (t - 1) % 3;
      if (t >= 1 && t < t_end && p == 2) z = zs[e];
      else z = N_CH'($urandom);
      #1;
      tt = $sformatf("%s.t%0d", tag, t);
      if (t == 0) check_outs(tt, 1, 0, 1, 0, 0, 0, 0);
      else if (t < t_end)
        check_outs(tt, 0, (p == 2) ? 1 : 0, 1, 0, 0, (p == 2) ? lowest_zero(zs[e]) : 0, e);
      else
        check_outs(tt, 0, 0, 0, 1, ($countones(zs[e_fin]) < K_MIN) ? 1 : 0, 0, e_fin);
      if (t == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        z = N_CH'($urandom);
        #1;
        check_outs({tag, ".abort"}, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_outs({tag, ".abort_hold"}, 0, 0, 0, 0, 0, 0, 0);
        return;
      end
      if (t < t_end + hold) tick();
    end
  endtask

  initial begin
    logic [N_CH-1:0] zs [MAX_ITER];
    int abort_at;

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    z     = '0;
    #3;
    check_outs("reset_async", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    z     = 4'b0101;
    tick();
    check_outs("reset_held", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    #2 rst = 1'b0;
    tick();
    check_outs("idle_0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("idle_1", 0, 0, 0, 0, 0, 0, 0);

    zs = '{4'b0111, 4'b0111, 4'b0111, 4'b0111};
    do_run("first_eval_ok", zs, -1, 2);
    zs = '{4'b0101, 4'b0101, 4'b0101, 4'b0101};
    do_run("timeout", zs, -1, 2);
    // Restart straight from DONE after a timeout
    zs = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
    do_run("retry_then_ok", zs, -1, 1);
    zs = '{4'b0101, 4'b0101, 4'b0101, 4'b0101};
    do_run("abort_step_b", zs, 2, 0);
    zs = '{4'b0001, 4'b0010, 4'b0100, 4'b1110};
    do_run("ok_at_limit", zs, -1, 1);
    zs = '{4'b0011, 4'b0000, 4'b1000, 4'b0001};
    do_run("abort_in_done", zs, 3 * (MAX_ITER - 1) + 5, 2);

    // Asynchronous reset in the second EVAL of a run
    z     = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check_outs("rst_pre", 0, 1, 1, 0, 0, 1, 1);
    #2 rst = 1'b1;
    #1;
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("rst_mid_held", 0, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    tick();
    check_outs("rst_release_0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("rst_release_1", 0, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < MAX_ITER; k++) zs[k] = N_CH'($urandom);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 * MAX_ITER + 5)) : -1;
      do_run($sformatf("rnd%0d", r), zs, abort_at, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vote_sequencer.md
VOTE_SEQUENCER -- requirements
Module: vote_sequencer

Interface
REQ-001 Parameter N_CH, default 4: number of channel zero-flags; SHALL be ≥2.
REQ-002 Parameter K_MIN, default 3: flags that must be set to finish; SHALL be 1..N_CH.
REQ-003 Parameter MAX_ITER, default 15: maximum evaluations before timeout; SHALL be ≥1.
REQ-004 Derived SEL_W = max(1, clog2(N_CH)); derived IT_W = max(1, clog2(MAX_ITER)).
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin (or restart) a run.
REQ-008 abort  input  1  cancel the current run.
REQ-009 z  input  N_CH  per-channel zero flags from the datapath.
REQ-010 init  output  1  datapath load strobe.
REQ-011 upd  output  1  datapath update strobe.
REQ-012 sel  output  SEL_W  channel select for update.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  run finished.
REQ-015 timeout  output  1  run finished without reaching K_MIN.
REQ-016 iter_cnt  output  IT_W  count of failed evaluations in the current run.

Function
REQ-017 States SHALL be IDLE, INIT, STEP_A, STEP_B, EVAL, DONE, registered in one state register.
REQ-018 Transitions: IDLE→INIT when start=1 and otherwise hold; INIT→STEP_A; STEP_A→STEP_B; STEP_B→EVAL.
REQ-019 EVAL→DONE when popcount(z) ≥ K_MIN, and also when iter_cnt = MAX_ITER-1; otherwise EVAL→STEP_A.
REQ-020 DONE→INIT when start=1; otherwise hold DONE.
REQ-021 abort=1 in INIT, STEP_A, STEP_B or EVAL SHALL force IDLE at the next edge, overriding all other transitions.
REQ-022 abort=1 in IDLE or DONE SHALL force IDLE.
REQ-023 init=1 only in INIT; upd=1 only in EVAL; busy=1 in INIT, STEP_A, STEP_B and EVAL; done=1 only in DONE.
REQ-024 init, upd, busy and done SHALL depend only on the state register.
REQ-025 In EVAL, sel SHALL be the lowest index i with z[i]=0, or 0 when all flags are 1; sel is combinational from z.
REQ-026 Outside EVAL, sel SHALL be 0.
REQ-027 iter_cnt SHALL clear on entry to INIT, increment on each EVAL→STEP_A transition, and never wrap.
REQ-028 iter_cnt SHALL hold its value in DONE and IDLE except as stated in REQ-027 and REQ-029.
REQ-029 On abort, iter_cnt SHALL clear.
REQ-030 The timeout register SHALL set on an EVAL→DONE transition with popcount(z) < K_MIN, and clear on entry to INIT or IDLE.
REQ-031 If the threshold and iteration limit are both met in the same EVAL, timeout SHALL stay 0.
REQ-032 Latency: with the start-sampling edge as edge 0, done SHALL rise after edge 4 when the first EVAL succeeds.
REQ-033 Each failed evaluation SHALL add exactly 3 cycles to that latency.
REQ-034 Popcount SHALL use a full-width (clog2(N_CH+1)-bit) count with no truncation.

Reset
REQ-035 While rst=1, the state SHALL be IDLE and iter_cnt and timeout SHALL be 0, immediately and regardless of clk.
REQ-036 During reset, init, upd, busy, done, timeout and sel SHALL all be 0.
REQ-037 rst asserted mid-run SHALL abandon the run; after release, the block SHALL wait in IDLE for start.

Verification (N_CH=4, K_MIN=3, MAX_ITER=4)
REQ-038 start pulse, z=4'b0111 held -> init after edge 0, upd=1 with sel=3 after edge 3, then done=1 after edge 4 with timeout=0 and iter_cnt=0.
REQ-039 z=4'b0101 held -> 4 EVALs, each with sel=1 -> done=1, timeout=1, iter_cnt=3.
REQ-040 z=4'b0000 in first EVAL, then 4'b1111 -> first EVAL sel=0 and returns to STEP_A; second EVAL sel=0 -> done with iter_cnt=1 and timeout=0.
REQ-041 abort=1 while in STEP_B -> IDLE next edge with busy=0, done=0, iter_cnt=0; IDLE holds with start=0.
REQ-042 start=1 while in DONE after a timeout -> INIT next edge with timeout=0 and iter_cnt=0.
REQ-043 rst pulse during EVAL, asynchronous to clk -> all outputs 0 immediately; IDLE held after release until start.
